core_mem_port: RTL and testbench

Per-core memory port between a core's load/store unit and one slot of the 4-core memory arbiter. It turns the core's valid/ready transactions into the arbiter's level request / response-pulse protocol and holds the address, data and write-enable stable for the whole arbiter wait. It optionally posts writes into a small in-order queue so the core does not stall on stores. One instance is placed per core, wired to the arbiter's `request[i]`, `wren_core[i]`, `address_in_core<i>`, `data_in_core<i>`, `data_out_core<i>` and `response[i]`.

---
 rtl/mem_pkg.sv | 15 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/core_mem_port.sv | 169 ++++++++++++++++
 tb/tb_core_mem_port.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the per-core memory port.
//   mem_state_t   - port FSM encoding (IDLE, READ, WRITE, ACK)
//   DEFAULT_WIDTH - default data/address width
package mem_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock in-order FIFO used as the posted-write queue.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (discards contents)
//   push, din    - write an entry (caller must not push when full)
//   pop, dout    - remove head entry; dout shows the head combinationally
//   full, empty  - occupancy flags
//   count        - number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/core_mem_port.sv
// core_mem_port: per-core bridge from a load/store valid/ready interface to
// one slot of the 4-core memory arbiter (level request, response pulse).
// Optional feature macro: CORE_MEM_PORT_POSTED_WRITE_EN
//   defined   - writes are posted into an in-order queue and complete at once
//   undefined - writes travel the read path with arb_wren=1; wq_count is 0
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   core_valid/we/addr/wdata          - core request (held until core_ready)
//   core_ready, core_rdata            - completion pulse, read data
//   arb_request/wren/address/data_write - registered arbiter request
//   arb_response, arb_data_read       - arbiter completion pulse, read data
//   wq_count                          - write-queue occupancy
//   timeout_err                       - sticky request watchdog flag
module core_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned WQ_DEPTH = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_valid,
  input  logic                      core_we,
  input  logic [WIDTH-1:0]          core_addr,
  input  logic [WIDTH-1:0]          core_wdata,
  output logic                      core_ready,
  output logic [WIDTH-1:0]          core_rdata,
  output logic                      arb_request,
  output logic                      arb_wren,
  output logic [WIDTH-1:0]          arb_address,
  output logic [WIDTH-1:0]          arb_data_write,
  input  logic                      arb_response,
  input  logic [WIDTH-1:0]          arb_data_read,
  output logic [$clog2(WQ_DEPTH):0] wq_count,
  output logic                      timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  mem_state_t       state, state_d;
  logic             req_d, wren_d, ready_d, err_d;
  logic [WIDTH-1:0] addr_d, wdata_d, rdata_d;
  logic [CNT_W-1:0] wdog_cnt, cnt_d;

`ifdef CORE_MEM_PORT_POSTED_WRITE_EN
  logic               wq_push, wq_pop, wq_full, wq_empty;
  logic [2*WIDTH-1:0] wq_head;

  // core_ready gating stops a just-completed write from being pushed twice
  assign wq_push = core_valid & core_we & ~wq_full & ~core_ready;
  assign wq_pop  = (state == ST_WRITE) & arb_response;

  sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wq_push),
    .pop   (wq_pop),
    .din   ({core_addr, core_wdata}),
    .dout  (wq_head),
    .full  (wq_full),
    .empty (wq_empty),
    .count (wq_count)
  );
`else
  assign wq_count = '0;
`endif

  always_comb begin
    state_d = state;
    req_d   = arb_request;
    wren_d  = arb_wren;
    addr_d  = arb_address;
    wdata_d = arb_data_write;
    rdata_d = core_rdata;
    ready_d = 1'b0;

    unique case (state)
      ST_IDLE: begin
`ifdef CORE_MEM_PORT_POSTED_WRITE_EN
        // Queue drains before any read so reads observe earlier stores.
        if (!wq_empty) begin
          state_d = ST_WRITE;
          req_d   = 1'b1;
          wren_d  = 1'b1;
          addr_d  = wq_head[2*WIDTH-1:WIDTH];
          wdata_d = wq_head[WIDTH-1:0];
        end else if (core_valid && !core_we && !core_ready) begin
          state_d = ST_READ;
          req_d   = 1'b1;
          wren_d  = 1'b0;
          addr_d  = core_addr;
          wdata_d = '0;
        end
`else
        if (core_valid && !core_ready) begin
          state_d = ST_READ;
          req_d   = 1'b1;
          wren_d  = core_we;
          addr_d  = core_addr;
          wdata_d = core_wdata;
        end
`endif
      end
      ST_READ: begin
        if (arb_response) begin
          state_d = ST_ACK;
          req_d   = 1'b0;
          wren_d  = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ready_d = 1'b1;
          // read data is kept until the next read, not overwritten by writes
          if (!arb_wren) rdata_d = arb_data_read;
        end
      end
      ST_WRITE: begin
        if (arb_response) begin
          state_d = ST_ACK;
          req_d   = 1'b0;
          wren_d  = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      ST_ACK: state_d = ST_IDLE;
    endcase

`ifdef CORE_MEM_PORT_POSTED_WRITE_EN
    if (wq_push) ready_d = 1'b1;
`endif

    // Counter tracks the registered request, so it equals the number of
    // request cycles so far including the current one.
    if (!req_d)                cnt_d = '0;
    else if (wdog_cnt != TMO_C) cnt_d = wdog_cnt + 1'b1;
    else                       cnt_d = wdog_cnt;
    err_d = timeout_err | (req_d && (cnt_d == TMO_C));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      arb_request    <= 1'b0;
      arb_wren       <= 1'b0;
      arb_address    <= '0;
      arb_data_write <= '0;
      core_ready     <= 1'b0;
      core_rdata     <= '0;
      wdog_cnt       <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_d;
      arb_request    <= req_d;
      arb_wren       <= wren_d;
      arb_address    <= addr_d;
      arb_data_write <= wdata_d;
      core_ready     <= ready_d;
      core_rdata     <= rdata_d;
      wdog_cnt       <= cnt_d;
      timeout_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_core_mem_port.sv
module tb_core_mem_port;

  localparam int unsigned W   = 32;
  localparam int unsigned WQD = 4;
  localparam int unsigned TMO = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   core_valid = 1'b0;
  logic                   core_we = 1'b0;
  logic [W-1:0]           core_addr = '0;
  logic [W-1:0]           core_wdata = '0;
  logic                   core_ready;
  logic [W-1:0]           core_rdata;
  logic                   arb_request;
  logic                   arb_wren;
  logic [W-1:0]           arb_address;
  logic [W-1:0]           arb_data_write;
  logic                   arb_response = 1'b0;
  logic [W-1:0]           arb_data_read = '0;
  logic [$clog2(WQD):0]   wq_count;
  logic                   timeout_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // arbiter model state
  logic [W-1:0] amem [256];
  int unsigned  arb_lat = 3;
  int unsigned  arb_k = 0;

  core_mem_port #(
    .WIDTH    (W),
    .WQ_DEPTH (WQD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_valid     (core_valid),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_ready     (core_ready),
    .core_rdata     (core_rdata),
    .arb_request    (arb_request),
    .arb_wren       (arb_wren),
    .arb_address    (arb_address),
    .arb_data_write (arb_data_write),
    .arb_response   (arb_response),
    .arb_data_read  (arb_data_read),
    .wq_count       (wq_count),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbiter: responds in request cycle arb_lat+1 (arb_lat cycles after rise).
  task automatic arb_step();
    arb_response = 1'b0;
    if (arb_request) begin
      arb_k++;
      if (arb_k == arb_lat + 1) begin
        arb_response = 1'b1;
        arb_k = 0;
        if (arb_wren) amem[arb_address[7:0]] = arb_data_write;
        else          arb_data_read = amem[arb_address[7:0]];
      end
    end else begin
      arb_k = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({core_ready, arb_request, arb_wren, timeout_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000", {core_ready, arb_request, arb_wren, timeout_err});
    end
    vectors++;
    if ((core_rdata | arb_address | arb_data_write) !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h/%h/%h expected 0", core_rdata, arb_address, arb_data_write);
    end
    vectors++;
    if (wq_count !== '0) begin
      miscompares++;
      $display("FAIL reset_wq_count: got %0d expected 0", wq_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    amem[8'h10] = 32'hDEADBEEF;
    core_valid = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({arb_request, arb_wren, core_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL read_wait[%0d]: req/wren/ready got %b expected 100", i, {arb_request, arb_wren, core_ready});
      end
      vectors++;
      if (arb_address !== 32'h10) begin
        miscompares++;
        $display("FAIL read_addr[%0d]: got %h expected 00000010", i, arb_address);
      end
    end
    arb_response = 1'b1; arb_data_read = 32'hDEADBEEF;
    tick();
    arb_response = 1'b0; arb_data_read = '0; core_valid = 1'b0;
    vectors++;
    if ({arb_request, arb_wren, core_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL read_done: req/wren/ready got %b expected 001", {arb_request, arb_wren, core_ready});
    end
    vectors++;
    if (core_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_data: got %h expected deadbeef", core_rdata);
    end
    tick();
    vectors++;
    if (core_ready !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_hold: ready %b rdata %h expected 0 deadbeef", core_ready, core_rdata);
    end
  endtask

  task automatic test_timeout();
    core_valid = 1'b1; core_we = 1'b0; core_addr = 32'h3C;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if (arb_request !== 1'b1) begin
        miscompares++;
        $display("FAIL tmo_req[%0d]: got %b expected 1", i, arb_request);
      end
      vectors++;
      if (timeout_err !== 1'(i >= 16)) begin
        miscompares++;
        $display("FAIL tmo_err[%0d]: got %b expected %b", i, timeout_err, 1'(i >= 16));
      end
    end
    arb_response = 1'b1; arb_data_read = 32'h12345678;
    tick();
    arb_response = 1'b0; arb_data_read = '0; core_valid = 1'b0;
    vectors++;
    if ({core_ready, arb_request, timeout_err} !== 3'b101 || core_rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL tmo_late: ready/req/err %b rdata %h expected 101 12345678", {core_ready, arb_request, timeout_err}, core_rdata);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b1 || core_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_sticky: err %b ready %b expected 1 0", timeout_err, core_ready);
    end
  endtask

  task automatic test_reset_during_read();
    core_valid = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    tick();
    tick();
    vectors++;
    if (arb_request !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rd_req: got %b expected 1", arb_request);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({core_ready, arb_request, arb_wren, timeout_err} !== 4'b0000 ||
        (core_rdata | arb_address | arb_data_write) !== '0 || wq_count !== '0) begin
      miscompares++;
      $display("FAIL rst_async: ctrl %b addr %h rdata %h cnt %0d expected all 0",
               {core_ready, arb_request, arb_wren, timeout_err}, arb_address, core_rdata, wq_count);
    end
    core_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    arb_response = 1'b1; arb_data_read = 32'hFFFFFFFF;
    tick();
    arb_response = 1'b0; arb_data_read = '0;
    vectors++;
    if ({core_ready, arb_request} !== 2'b00 || core_rdata !== '0) begin
      miscompares++;
      $display("FAIL stray_resp: ready/req %b rdata %h expected 00 0", {core_ready, arb_request}, core_rdata);
    end
    tick();
  endtask

`ifdef CORE_MEM_PORT_POSTED_WRITE_EN
  task automatic test_back_to_back();
    int unsigned exp_rdy[5]  = '{1, 3, 5, 7, 10};
    int unsigned exp_rise[5] = '{2, 11, 20, 29, 38};
    int unsigned rdy_t[5];
    int unsigned rise_t[5];
    logic [W-1:0] rise_a[5];
    logic [W-1:0] rise_d[5];
    int unsigned idx = 0, nrdy = 0, nrise = 0, unstable = 0, max_cnt = 0, wren_bad = 0;
    logic prev_req = 1'b0;
    logic [W-1:0] hold_a = '0, hold_d = '0;
    arb_lat = 6; arb_k = 0;
    core_valid = 1'b1; core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'hA0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (core_ready) begin
        if (nrdy < 5) rdy_t[nrdy] = t;
        nrdy++;
        idx++;
      end
      if (arb_request && !prev_req) begin
        if (nrise < 5) begin
          rise_t[nrise] = t; rise_a[nrise] = arb_address; rise_d[nrise] = arb_data_write;
        end
        nrise++;
        hold_a = arb_address; hold_d = arb_data_write;
      end
      if (arb_request && !arb_wren) wren_bad++;
      if (arb_request && prev_req && (arb_address !== hold_a || arb_data_write !== hold_d)) unstable++;
      if (int'(wq_count) > max_cnt) max_cnt = wq_count;
      prev_req = arb_request;
      arb_step();
      if (idx < 5) begin
        core_valid = 1'b1; core_addr = idx; core_wdata = 32'hA0 + idx;
      end else begin
        core_valid = 1'b0;
      end
    end
    vectors++;
    if (nrdy !== 5 || nrise !== 5) begin
      miscompares++;
      $display("FAIL b2b_counts: ready pulses %0d requests %0d expected 5 5", nrdy, nrise);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (rdy_t[i] !== exp_rdy[i]) begin
          miscompares++;
          $display("FAIL b2b_ready[%0d]: cycle %0d expected %0d", i, rdy_t[i], exp_rdy[i]);
        end
        vectors++;
        if (rise_t[i] !== exp_rise[i]) begin
          miscompares++;
          $display("FAIL b2b_rise[%0d]: cycle %0d expected %0d", i, rise_t[i], exp_rise[i]);
        end
        vectors++;
        if (rise_a[i] !== W'(i) || rise_d[i] !== W'(32'hA0 + i)) begin
          miscompares++;
          $display("FAIL b2b_order[%0d]: addr %h data %h expected %h %h", i, rise_a[i], rise_d[i], i, 32'hA0 + i);
        end
      end
    end
    vectors++;
    if (unstable !== 0 || wren_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_hold: unstable %0d wren-low %0d expected 0 0", unstable, wren_bad);
    end
    vectors++;
    if (max_cnt !== WQD || wq_count !== '0 || arb_request !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_queue: max %0d final %0d req %b expected 4 0 0", max_cnt, wq_count, arb_request);
    end
  endtask

  task automatic test_raw();
    int unsigned rise_t[2];
    logic rise_w[2];
    int unsigned nrise = 0, phase = 0, wr_rdy = 0, rd_rdy = 0;
    logic [W-1:0] rd_val = '0;
    logic prev_req = 1'b0;
    arb_lat = 3; arb_k = 0; amem[8'h20] = '0;
    core_valid = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h55;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (arb_request && !prev_req) begin
        if (nrise < 2) begin rise_t[nrise] = t; rise_w[nrise] = arb_wren; end
        nrise++;
      end
      prev_req = arb_request;
      if (core_ready) begin
        if (phase == 0) begin
          wr_rdy = t; phase = 1;
          core_we = 1'b0; core_wdata = '0;
        end else if (phase == 1) begin
          rd_rdy = t; rd_val = core_rdata; phase = 2;
          core_valid = 1'b0;
        end
      end
      arb_step();
    end
    vectors++;
    if (nrise !== 2) begin
      miscompares++;
      $display("FAIL raw_requests: got %0d expected 2", nrise);
    end else begin
      vectors++;
      if (rise_t[0] !== 2 || rise_w[0] !== 1'b1 || rise_t[1] !== 8 || rise_w[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL raw_order: rises %0d/%0d wren %b/%b expected 2/8 1/0", rise_t[0], rise_t[1], rise_w[0], rise_w[1]);
      end
    end
    vectors++;
    if (wr_rdy !== 1 || rd_rdy !== 12) begin
      miscompares++;
      $display("FAIL raw_ready: write %0d read %0d expected 1 12", wr_rdy, rd_rdy);
    end
    vectors++;
    if (rd_val !== 32'h55) begin
      miscompares++;
      $display("FAIL raw_data: got %h expected 00000055", rd_val);
    end
  endtask
`else
  task automatic test_write_nonposted();
    int unsigned nrdy = 0, rdy_t = 0, rise_t = 0, cnt_bad = 0;
    logic prev_req = 1'b0;
    logic rise_w = 1'b0;
    logic [W-1:0] rise_a = '0, rise_d = '0;
    arb_lat = 3; arb_k = 0; amem[8'h08] = '0;
    core_valid = 1'b1; core_we = 1'b1; core_addr = 32'h8; core_wdata = 32'h1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (wq_count !== '0) cnt_bad++;
      if (arb_request && !prev_req && rise_t == 0) begin
        rise_t = t; rise_w = arb_wren; rise_a = arb_address; rise_d = arb_data_write;
      end
      prev_req = arb_request;
      if (core_ready) begin
        nrdy++; rdy_t = t; core_valid = 1'b0;
      end
      arb_step();
    end
    vectors++;
    if (rise_t !== 1 || rise_w !== 1'b1 || rise_a !== 32'h8 || rise_d !== 32'h1) begin
      miscompares++;
      $display("FAIL np_request: cycle %0d wren %b addr %h data %h expected 1 1 8 1", rise_t, rise_w, rise_a, rise_d);
    end
    vectors++;
    if (nrdy !== 1 || rdy_t !== 5) begin
      miscompares++;
      $display("FAIL np_ready: pulses %0d at %0d expected 1 at 5", nrdy, rdy_t);
    end
    vectors++;
    if (cnt_bad !== 0 || amem[8'h08] !== 32'h1) begin
      miscompares++;
      $display("FAIL np_queue: nonzero wq_count cycles %0d mem %h expected 0 00000001", cnt_bad, amem[8'h08]);
    end
    vectors++;
    if (core_rdata !== '0) begin
      miscompares++;
      $display("FAIL np_rdata: got %h expected 0", core_rdata);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) amem[i] = '0;
    test_reset();
    test_read();
    test_timeout();
    test_reset_during_read();
`ifdef CORE_MEM_PORT_POSTED_WRITE_EN
    test_back_to_back();
    test_raw();
`else
    test_write_nonposted();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
